ring_scan_mux: RTL and testbench
================================

Name: ring_scan_mux

Overview:
- Parametrised time-multiplexed channel scanner: an internal one-hot ring sequencer plus an N-channel, W-bit AND-OR multiplexer.
- The ring dwells DWELL cycles on each channel. Masked-out channels are skipped. The ring state is exported so downstream blocks (display digit drivers, sensor polling) can share it.
- Successor to the fixed 4x1 ring-driven mux. Adds width/channel parametrisation, dwell timing, a channel mask, enable/hold, a registered output and frame status.

Parameters:
CHANNELS, 4, number of input channels (>=2)
WIDTH, 1, bits per channel
DWELL, 1000, clock cycles spent on each selected channel (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = dwell counter and ring run; 0 = hold current slot
channel_mask  input  CHANNELS  1 = channel participates in scan
data_in  input  CHANNELS*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]
data_out  output  WIDTH  registered data of currently selected channel
ring  output  CHANNELS  one-hot select of current channel (all-zero only when mask is zero)
slot_start  output  1  one-cycle pulse in the first cycle of each new slot
frame_done  output  1  one-cycle pulse when ring wraps from highest to lowest enabled channel

Behaviour:
- Reset (async assert, sync-safe deassert):
  - ring = 1 (channel 0); dwell counter = 0.
  - data_out = 0, slot_start = 0, frame_done = 0.
  - Asserting reset mid-dwell abandons the slot immediately.
- Dwell counter: width max(1, clog2(DWELL)).
  - Counts 0..DWELL-1 while enable=1.
  - At DWELL-1 it returns to 0 and the ring advances on the same edge.
  - DWELL=1: advance every enabled cycle.
- Advance:
  - ring takes the next set bit of channel_mask strictly above the current index, wrapping to the lowest set bit.
  - Single enabled channel: ring stays put but still counts as an advance (slot_start and frame_done pulse every DWELL cycles).
- slot_start: high in the cycle after any ring load (advance, forced move, or recovery from empty mask). Not asserted after reset.
- frame_done: high together with slot_start when the new index <= the old index (wrap).
- enable=0:
  - Counter and ring frozen; no pulses.
  - data_out keeps tracking data_in of the held channel.
- Mask clears the current channel mid-dwell (regardless of enable): on the next edge the ring moves to the next enabled channel, the counter is reset to 0, and slot_start pulses (frame_done if that move wrapped).
- Mask becomes all-zero:
  - Next edge: ring = 0, counter = 0, data_out = 0; no pulses while empty.
  - When the mask becomes non-zero again: ring loads the lowest set bit next edge, with slot_start=1 and frame_done=0.
- data_out:
  - Each edge, registered OR over k of (data_in channel k AND ring[k]), using the current ring value.
  - Latency: 1 cycle behind ring; data changes propagate in 1 cycle.
- Invariant: ring is one-hot or zero. It is never multi-hot, including under simultaneous mask change and dwell expiry. In that case the mask change wins and follows the forced-move rule with the counter reset.

Decomposition:
- Shared package (scan_pkg):
  - Function next_enabled(ring, mask) returning the next one-hot.
  - Function clog2_min1.
- Natural sub-module: ring_sequencer_n, containing the dwell counter, ring register, mask handling and pulses. It exports ring, slot_start and frame_done.
- Top level: ring_scan_mux instantiates ring_sequencer_n and the registered AND-OR mux (generate loop over CHANNELS).

Test Plan:
- CHANNELS=4, WIDTH=4, DWELL=3, mask=1111, enable=1, data_in={D,C,B,A}:
  - ring = 0001,0010,0100,1000,0001 each for 3 cycles.
  - data_out = A,B,C,D one cycle later.
  - frame_done pulses once per 12 cycles, on the return to 0001.
- Mask=0101 from reset: ring alternates 0001/0100; ring never equals 0010 or 1000; frame_done every 6 cycles.
- Clear mask bit 1 while ring=0010 at counter=1: next cycle ring=0100, counter=0, slot_start=1, frame_done=0.
- Mask=0000 for 5 cycles, then 1000: ring=0000 and data_out=0 while empty; then ring=1000 with slot_start=1 and frame_done=0.
- enable=0 for 10 cycles mid-slot: ring and counter unchanged, no pulses; changing data_in of the held channel updates data_out after 1 cycle; on enable=1 the slot resumes its remaining count.
- Assert reset mid-scan (ring=0100), asynchronously between edges: outputs go to ring=0001 and data_out=0 immediately; DWELL=1 build advances every cycle after release.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared helpers for the ring scanner: one-hot successor search, counter sizing
// and the registered per-slot event pair.
package scan_pkg;

   localparam int unsigned MAX_CH = 64;

   typedef logic [MAX_CH-1:0] chvec_t;

   typedef struct packed {
      logic slot_start;
      logic frame_done;
   } scan_evt_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Lowest mask bit strictly above the one-hot ring, else the lowest mask bit.
   // A zero ring therefore yields the lowest set bit of the mask.
   function automatic chvec_t next_enabled(input chvec_t ring, input chvec_t mask);
      chvec_t upto;
      chvec_t above;
      upto  = (ring << 1) - chvec_t'(1);
      above = mask & ~upto;
      if (|above) return above & (~above + chvec_t'(1));
      return mask & (~mask + chvec_t'(1));
   endfunction

endpackage

// File: rtl/ring_sequencer_n.sv
// One-hot ring sequencer with dwell counter, channel mask handling and
// slot/frame pulses registered alongside the ring.
module ring_sequencer_n
   import scan_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DWELL    = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [CHANNELS-1:0] channel_mask,
   output logic [CHANNELS-1:0] ring,
   output logic                slot_start,
   output logic                frame_done
);

   localparam int unsigned   CW       = clog2_min1(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   logic [CHANNELS-1:0] ring_q, ring_d, nxt;
   logic [CW-1:0]       cnt_q, cnt_d;
   scan_evt_t           evt_q, evt_d;
   logic                wrap;

   assign nxt  = CHANNELS'(next_enabled(chvec_t'(ring_q), chvec_t'(channel_mask)));
   assign wrap = (nxt <= ring_q);

   always_comb begin
      ring_d = ring_q;
      cnt_d  = cnt_q;
      evt_d  = '0;
      if (channel_mask == '0) begin
         ring_d = '0;
         cnt_d  = '0;
      end else if (ring_q == '0) begin
         ring_d           = nxt;
         cnt_d            = '0;
         evt_d.slot_start = 1'b1;
      end else if ((ring_q & channel_mask) == '0 || (enable && cnt_q == CNT_LAST)) begin
         // A dropped live channel forces the move even while held, and wins
         // over a coincident dwell expiry so the ring stays one-hot.
         ring_d           = nxt;
         cnt_d            = '0;
         evt_d.slot_start = 1'b1;
         evt_d.frame_done = wrap;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ring_q <= CHANNELS'(1);
         cnt_q  <= '0;
         evt_q  <= '0;
      end else begin
         ring_q <= ring_d;
         cnt_q  <= cnt_d;
         evt_q  <= evt_d;
      end
   end

   assign ring       = ring_q;
   assign slot_start = evt_q.slot_start;
   assign frame_done = evt_q.frame_done;

endmodule

// File: rtl/ring_scan_mux.sv
// Time-multiplexed channel scanner: ring sequencer driving a registered
// AND-OR multiplexer over CHANNELS inputs of WIDTH bits.
module ring_scan_mux
   import scan_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned DWELL    = 1000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [CHANNELS-1:0]       channel_mask,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]          data_out,
   output logic [CHANNELS-1:0]       ring,
   output logic                      slot_start,
   output logic                      frame_done
);

   logic [CHANNELS-1:0][WIDTH-1:0] term;
   logic [WIDTH-1:0]               data_d, data_q;

   ring_sequencer_n #(
      .CHANNELS(CHANNELS),
      .DWELL   (DWELL)
   ) u_seq (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .channel_mask(channel_mask),
      .ring        (ring),
      .slot_start  (slot_start),
      .frame_done  (frame_done)
   );

   genvar k;
   generate
      for (k = 0; k < CHANNELS; k++) begin : g_term
         assign term[k] = data_in[k*WIDTH +: WIDTH] & {WIDTH{ring[k]}};
      end
   endgenerate

   // An empty mask blanks the output on the same edge the ring clears.
   always_comb begin
      data_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) data_d |= term[i];
      if (channel_mask == '0) data_d = '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) data_q <= '0;
      else       data_q <= data_d;
   end

   assign data_out = data_q;

endmodule

// File: tb/tb_ring_scan_mux.sv
// Bench for ring_scan_mux: DWELL=3 and DWELL=1 instances on shared stimulus,
// an index-based behavioural model compared every cycle, plus literal pins.
module tb_ring_scan_mux;

   localparam int CH = 4;
   localparam int W  = 4;

   logic            clock, reset, enable;
   logic [CH-1:0]   channel_mask;
   logic [CH*W-1:0] data_in;
   logic [W-1:0]    dout3, dout1;
   logic [CH-1:0]   ring3, ring1;
   logic            slot3, slot1, frame3, frame1;

   int n_chk  = 0;
   int n_fail = 0;

   ring_scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(3)) dut3 (
      .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
      .data_in(data_in), .data_out(dout3), .ring(ring3),
      .slot_start(slot3), .frame_done(frame3));

   ring_scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(1)) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
      .data_in(data_in), .data_out(dout1), .ring(ring1),
      .slot_start(slot1), .frame_done(frame1));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: channel index (-1 = empty) and elapsed dwell per instance.
   int          m_idx[2];
   int          m_cnt[2];
   bit          m_slot[2];
   bit          m_frame[2];
   logic [W-1:0] m_data[2];

   function automatic int next_ch(input int idx, input logic [CH-1:0] m);
      for (int i = 1; i <= CH; i++)
         if (m[(idx + i) % CH]) return (idx + i) % CH;
      return -1;
   endfunction

   function automatic logic [CH-1:0] ring_of(input int u);
      logic [CH-1:0] r;
      r = '0;
      if (m_idx[u] >= 0) r[m_idx[u]] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_idx[u] = 0; m_cnt[u] = 0; m_slot[u] = 0; m_frame[u] = 0; m_data[u] = '0;
      end
   endtask

   task automatic model_step(input int u, input int dw);
      int n;
      m_slot[u]  = 0;
      m_frame[u] = 0;
      m_data[u]  = (channel_mask == '0 || m_idx[u] < 0) ? '0 : data_in[m_idx[u]*W +: W];
      if (channel_mask == '0) begin
         m_idx[u] = -1;
         m_cnt[u] = 0;
      end else if (m_idx[u] < 0 || !channel_mask[m_idx[u]] || (enable && m_cnt[u] == dw - 1)) begin
         n          = next_ch(m_idx[u], channel_mask);
         m_frame[u] = (m_idx[u] >= 0) && (n <= m_idx[u]);
         m_slot[u]  = 1;
         m_idx[u]   = n;
         m_cnt[u]   = 0;
      end else if (enable) begin
         m_cnt[u]++;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) model_reset();
         else begin
            model_step(0, 3);
            model_step(1, 1);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         check("m3_ring",  32'(ring3),  32'(ring_of(0)));
         check("m3_data",  32'(dout3),  32'(m_data[0]));
         check("m3_slot",  32'(slot3),  32'(m_slot[0]));
         check("m3_frame", 32'(frame3), 32'(m_frame[0]));
         check("m1_ring",  32'(ring1),  32'(ring_of(1)));
         check("m1_data",  32'(dout1),  32'(m_data[1]));
         check("m1_slot",  32'(slot1),  32'(m_slot[1]));
         check("m1_frame", 32'(frame1), 32'(m_frame[1]));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_for(input string name, input logic [CH-1:0] want, input bit need_slot);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         tick(1);
         ok = (ring3 == want) && (!need_slot || slot3);
      end
      check(name, 32'(ok), 32'd1);
   endtask

   initial begin
      int cnt, cnt1, bad;
      reset = 1'b0; enable = 1'b1; channel_mask = 4'b1111; data_in = 16'hE953;
      #2 reset = 1'b1;
      #10;
      check("rst_ring",  32'(ring3),  32'd1);
      check("rst_data",  32'(dout3),  32'd0);
      check("rst_slot",  32'(slot3),  32'd0);
      check("rst_frame", 32'(frame3), 32'd0);
      @(posedge clock); #1 reset = 1'b0;

      // Full scan, DWELL=3
      tick(2);
      check("scan_r0", 32'(ring3), 32'd1);
      check("scan_d0", 32'(dout3), 32'h3);
      tick(1);
      check("scan_r1",    32'(ring3), 32'd2);
      check("scan_slot1", 32'(slot3), 32'd1);
      check("scan_dlag",  32'(dout3), 32'h3);
      tick(1);
      check("scan_d1",    32'(dout3), 32'h5);
      check("scan_slot0", 32'(slot3), 32'd0);
      cnt = 0; cnt1 = 0;
      repeat (12) begin tick(1); cnt += int'(frame3); cnt1 += int'(frame1); end
      check("frame3_per12", 32'(cnt),  32'd1);
      check("frame1_per12", 32'(cnt1), 32'd3);

      // Sparse mask from reset
      reset = 1'b1; tick(1);
      channel_mask = 4'b0101; reset = 1'b0;
      cnt = 0; cnt1 = 0; bad = 0;
      repeat (24) begin
         tick(1);
         bad  += (ring3 == 4'b0010 || ring3 == 4'b1000) ? 1 : 0;
         cnt  += int'(frame3);
         cnt1 += int'(frame1);
      end
      check("sparse_skip",   32'(bad),  32'd0);
      check("sparse_frame3", 32'(cnt),  32'd4);
      check("sparse_frame1", 32'(cnt1), 32'd12);

      // Clear the live channel mid-dwell
      channel_mask = 4'b1111;
      wait_for("wait_ch1", 4'b0010, 1'b1);
      tick(1);
      channel_mask = 4'b1101;
      tick(1);
      check("force_ring",  32'(ring3),  32'd4);
      check("force_slot",  32'(slot3),  32'd1);
      check("force_frame", 32'(frame3), 32'd0);
      check("force_dold",  32'(dout3),  32'h5);
      tick(1);
      check("force_dnew", 32'(dout3), 32'h9);
      tick(1);
      check("force_stay", 32'(ring3), 32'd4);
      tick(1);
      check("force_next", 32'(ring3), 32'd8);

      // Empty mask then recovery
      channel_mask = 4'b0000;
      bad = 0;
      repeat (5) begin
         tick(1);
         bad += (ring3 != 0 || dout3 != 0 || slot3 || frame3 || ring1 != 0) ? 1 : 0;
      end
      check("empty_quiet", 32'(bad), 32'd0);
      channel_mask = 4'b1000;
      tick(1);
      check("recov_ring",  32'(ring3),  32'd8);
      check("recov_slot",  32'(slot3),  32'd1);
      check("recov_frame", 32'(frame3), 32'd0);
      check("recov_ring1", 32'(ring1),  32'd8);
      tick(1);
      check("recov_data", 32'(dout3), 32'hE);

      // Hold mid-slot
      channel_mask = 4'b1111; enable = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         bad += (ring3 != 4'b1000 || slot3 || frame3 || slot1 || frame1) ? 1 : 0;
         if (i == 4) data_in = 16'h7953;
         if (i == 5) check("hold_data", 32'(dout3), 32'h7);
      end
      check("hold_frozen", 32'(bad), 32'd0);
      enable = 1'b1;
      tick(1);
      check("resume_stay", 32'(ring3), 32'd8);
      check("resume_noslot", 32'(slot3), 32'd0);
      tick(1);
      check("resume_ring",  32'(ring3),  32'd1);
      check("resume_slot",  32'(slot3),  32'd1);
      check("resume_frame", 32'(frame3), 32'd1);
      check("resume_data",  32'(dout3),  32'h7);
      data_in = 16'hE953;

      // Asynchronous reset mid-scan
      wait_for("wait_ch2", 4'b0100, 1'b0);
      #3 reset = 1'b1;
      #1;
      check("arst_ring3", 32'(ring3), 32'd1);
      check("arst_data3", 32'(dout3), 32'd0);
      check("arst_ring1", 32'(ring1), 32'd1);
      check("arst_data1", 32'(dout1), 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      tick(1);
      check("d1_r1",    32'(ring1), 32'd2);
      check("d1_slot",  32'(slot1), 32'd1);
      tick(1);
      check("d1_r2",    32'(ring1), 32'd4);
      check("d1_hold3", 32'(ring3), 32'd1);
      tick(1);
      check("d1_r3",    32'(ring1), 32'd8);
      tick(1);
      check("d1_r0",    32'(ring1),  32'd1);
      check("d1_frame", 32'(frame1), 32'd1);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
